aes_cbc_dec_ctrl: RTL and testbench

CBC/ECB chaining controller that sits directly upstream and downstream of the AES decipher block. It accepts ciphertext blocks on a valid/ready stream and issues a `next` pulse to the decipher core. When the core reports `ready`, it takes the raw decrypted block and XORs it with the chaining value (IV or previous ciphertext) in CBC mode, then presents the plaintext on an output valid/ready stream. Key expansion and `round_key` delivery stay in the existing key memory; this block only sequences data.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_cbc_dec_ctrl.sv | 117 +++++++++++
 tb/tb_aes_cbc_dec_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width and the chaining-controller FSM encoding.
`timescale 1ns/1ps
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_ISSUE = 2'd1,
        CTRL_WAIT  = 2'd2,
        CTRL_OUT   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/aes_cbc_dec_ctrl.sv
// CBC/ECB chaining controller around the AES decipher core: issues one block at a
// time, XORs the raw result with the chaining value and presents the plaintext.
`timescale 1ns/1ps
module aes_cbc_dec_ctrl
    import aes_pkg::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mode_cbc,
    input  logic                   iv_load,
    input  logic [AES_BLOCK_W-1:0] iv,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   dec_next,
    output logic [AES_BLOCK_W-1:0] dec_block,
    input  logic                   dec_ready,
    input  logic [AES_BLOCK_W-1:0] dec_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy,
    output logic [CTR_WIDTH-1:0]   blocks_done
);

    ctrl_state_t state_reg, state_next;

    logic [AES_BLOCK_W-1:0] cipher_reg;
    logic [AES_BLOCK_W-1:0] chain_reg;
    logic [AES_BLOCK_W-1:0] out_reg;
    logic                   mode_reg;
    logic                   first_wait_reg;
    logic [CTR_WIDTH-1:0]   blocks_done_reg;

    logic load_iv;
    logic accept;
    logic capture;
    logic out_hs;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        dec_next   = 1'b0;
        load_iv    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        out_hs     = 1'b0;
        case (state_reg)
            CTRL_IDLE: begin
                in_ready = !iv_load;
                if (iv_load) begin
                    load_iv = 1'b1;
                end else if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CTRL_ISSUE;
                end
            end
            CTRL_ISSUE: begin
                dec_next   = 1'b1;
                state_next = CTRL_WAIT;
            end
            CTRL_WAIT: begin
                // The core's ready is still high from the previous block on the first WAIT cycle.
                if (!first_wait_reg && dec_ready) begin
                    capture    = 1'b1;
                    state_next = CTRL_OUT;
                end
            end
            CTRL_OUT: begin
                if (out_ready) begin
                    out_hs     = 1'b1;
                    state_next = CTRL_IDLE;
                end
            end
            default: state_next = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= CTRL_IDLE;
            cipher_reg      <= '0;
            chain_reg       <= '0;
            out_reg         <= '0;
            mode_reg        <= 1'b0;
            first_wait_reg  <= 1'b0;
            blocks_done_reg <= '0;
        end else begin
            state_reg      <= state_next;
            first_wait_reg <= (state_reg == CTRL_ISSUE);
            if (load_iv) begin
                chain_reg <= iv;
            end else if (capture && mode_reg) begin
                chain_reg <= cipher_reg;
            end
            if (accept) begin
                cipher_reg <= in_block;
                mode_reg   <= mode_cbc;
            end
            if (capture) begin
                out_reg <= dec_result ^ (mode_reg ? chain_reg : '0);
            end
            if (out_hs) begin
                blocks_done_reg <= blocks_done_reg + CTR_WIDTH'(1);
            end
        end
    end

    assign dec_block   = cipher_reg;
    assign out_valid   = (state_reg == CTRL_OUT);
    assign out_block   = out_reg;
    assign busy        = (state_reg != CTRL_IDLE);
    assign blocks_done = blocks_done_reg;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Bench for aes_cbc_dec_ctrl with a behavioural decipher-core stand-in and an output scoreboard.
`timescale 1ns/1ps
module tb_aes_cbc_dec_ctrl;
    import aes_pkg::*;

    localparam int CW  = 4;
    localparam int LAT = 51;

    localparam logic [127:0] IV0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_ECB = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_ECB = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1    = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2    = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] C3    = 128'h73bed6b8e3c1743b7116e69e22229516;
    localparam logic [127:0] C4    = 128'h3ff1caa1681fac09120eca307586e1a7;
    localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3    = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4    = 128'hf69f2445df4f9b17ad2b417be66c3710;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           mode_cbc = 1'b0;
    logic           iv_load = 1'b0;
    logic [127:0]   iv = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_block = '0;
    logic           dec_next;
    logic [127:0]   dec_block;
    logic           dec_ready;
    logic [127:0]   dec_result;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [127:0]   out_block;
    logic           busy;
    logic [CW-1:0]  blocks_done;

    int n_checks = 0;
    int n_fail   = 0;
    int next_seen = 0;
    int cnt_m = 0;
    logic [127:0] chain_m = '0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    aes_cbc_dec_ctrl #(.CTR_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .mode_cbc(mode_cbc), .iv_load(iv_load), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .dec_next(dec_next), .dec_block(dec_block), .dec_ready(dec_ready),
        .dec_result(dec_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .busy(busy), .blocks_done(blocks_done)
    );

    // Raw decipher output of the stand-in core: real AES results for the known vectors.
    function automatic logic [127:0] raw_of(input logic [127:0] c);
        case (c)
            C_ECB:   return P_ECB;
            C1:      return P1 ^ IV0;
            C2:      return P2 ^ C1;
            C3:      return P3 ^ C2;
            C4:      return P4 ^ C3;
            default: return {c[95:0], c[127:96]} ^ 128'h0123456789abcdeffedcba9876543210;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core stand-in: ready falls one cycle after next, rises LAT edges after the next edge.
    int           core_cnt;
    logic [127:0] core_pend;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_cnt   <= 0;
            core_pend  <= '0;
            dec_ready  <= 1'b1;
            dec_result <= '0;
        end else if (dec_next) begin
            core_cnt   <= LAT;
            core_pend  <= raw_of(dec_block);
            dec_result <= '0;
        end else if (core_cnt > 0) begin
            core_cnt   <= core_cnt - 1;
            dec_ready  <= (core_cnt == 1);
            dec_result <= (core_cnt == 1) ? core_pend : '0;
        end
    end

    always @(posedge clk) begin
        if (reset_n && dec_next) next_seen <= next_seen + 1;
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 128'(out_valid), 128'(0));
            end else begin
                check_eq("out_block", out_block, exp_q.pop_front());
                cnt_m = (cnt_m + 1) % (1 << CW);
            end
        end
    end

    task automatic send(input logic [127:0] c, input logic m);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) check_eq("in_ready_timeout", 128'(in_ready), 128'(1));
        exp_q.push_back(raw_of(c) ^ (m ? chain_m : '0));
        if (m) chain_m = c;
        in_block = c; mode_cbc = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode_cbc = ~m;
        in_block = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 300);
        if (busy) check_eq("idle_timeout", 128'(busy), 128'(0));
        check_eq("blocks_done", 128'(blocks_done), 128'(cnt_m));
    endtask

    task automatic run_block(input logic [127:0] c, input logic m);
        send(c, m);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_dec_next"}, 128'(dec_next), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_blocks_done"}, 128'(blocks_done), 128'(0));
        check_eq({tag, "_out_block"}, out_block, 128'(0));
        check_eq({tag, "_dec_block"}, dec_block, 128'(0));
        check_eq({tag, "_chain"}, dut.chain_reg, 128'(0));
    endtask

    initial begin
        int n0;
        int t;
        logic [127:0] cx, cy, cz;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ECB known-answer vector
        n0 = next_seen;
        run_block(C_ECB, 1'b0);
        check_eq("ecb_next_pulses", 128'(next_seen - n0), 128'(1));

        // CBC known-answer vectors
        iv = IV0; iv_load = 1'b1;
        @(posedge clk); #1;
        iv_load = 1'b0;
        chain_m = IV0;
        run_block(C1, 1'b1);
        run_block(C2, 1'b1);
        run_block(C3, 1'b1);
        run_block(C4, 1'b1);
        check_eq("cbc_chain_last", dut.chain_reg, C4);

        // Output backpressure
        out_ready = 1'b0;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("bp_out_valid", 128'(out_valid), 128'(1));
        n0 = next_seen;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i % 25 == 0) begin
                check_eq("bp_out_block", out_block, exp_q[0]);
                check_eq("bp_in_ready", 128'(in_ready), 128'(0));
                check_eq("bp_no_next", 128'(next_seen - n0), 128'(0));
                check_eq("bp_count_hold", 128'(blocks_done), 128'(cnt_m));
            end
        end
        out_ready = 1'b1;
        wait_idle();

        // iv_load collides with in_valid in IDLE
        cx = {$urandom, $urandom, $urandom, $urandom};
        cy = {$urandom, $urandom, $urandom, $urandom};
        iv = 128'hfeedface_0badf00d_cafebabe_12345678;
        iv_load = 1'b1; in_valid = 1'b1; in_block = cx; mode_cbc = 1'b1;
        @(negedge clk);
        check_eq("coll_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check_eq("coll_not_busy", 128'(busy), 128'(0));
        check_eq("coll_iv_loaded", dut.chain_reg, iv);
        chain_m = iv;
        iv_load = 1'b0;
        exp_q.push_back(raw_of(cx) ^ chain_m);
        chain_m = cx;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("coll_accepted", 128'(busy), 128'(1));
        repeat (10) @(posedge clk);
        #1 iv = 128'h11112222_33334444_55556666_77778888; iv_load = 1'b1;
        @(posedge clk); #1 iv_load = 1'b0;
        wait_idle();
        check_eq("wait_iv_ignored", dut.chain_reg, cx);
        run_block(cy, 1'b1);

        // Reset while waiting on the core
        cz = {$urandom, $urandom, $urandom, $urandom};
        send(cz, 1'b0);
        t = 0;
        while (next_seen == 0 && t < 0) t++;
        n0 = next_seen;
        t = 0;
        while (next_seen == n0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("rst_next_seen", 128'(next_seen - n0), 128'(0) + 128'(next_seen > n0 ? next_seen - n0 : 1));
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        chain_m = '0;
        cnt_m = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_block(C_ECB, 1'b0);

        // Sixteen more blocks wrap the 4-bit counter back to 1
        for (int i = 0; i < 16; i++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        check_eq("ctr_wrap", 128'(blocks_done), 128'(1));
        check_eq("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
